tdmseg4_rx: RTL
===============

Name: tdmseg4_rx

Overview:
- Receiving end of the 4-digit time-multiplexed 7-segment bus: samples segment[6:0] and the one-hot digit enable dden[3:0], decodes each glyph back to BCD and assembles a 4-digit frame.
- Converts the frame to a 14-bit binary value (0-9999) and publishes it only after STABLE identical consecutive frames.
- Used for loopback self-test of the display path and for links where a board forwards its display bus to another FPGA.

Parameters:
- STABLE, 2, number of consecutive identical decoded frames required before data updates (1-15).

Ports:
- clk  input  1  system clock; same clock the display bus is launched on (1 kHz nominal)
- rstn  input  1  reset, asynchronous, active-low
- segment  input  7  glyph, bit6..bit0 = G,F,E,D,C,B,A, common-cathode (1 = lit)
- dden  input  4  digit enable, one-hot; dden[0] = LSB digit
- data  output  14  last stable decoded value, binary 0-9999
- valid  output  1  one-cycle pulse when data is loaded with a new value
- err  output  1  one-cycle pulse when a frame is discarded

Behaviour:
- Reset (rstn low, asynchronous): data=0, valid=0, err=0, slot mask=0000, frame-error flag=0, match count=0, have-data flag=0, FSM=IDLE. Reset during conversion abandons the frame with no pulses.
- Glyph decode (combinational, strict):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111100, 7=0000111, 8=1111111, 9=1100111
  - Any other pattern, including blank 0000000, is invalid.
- Per-cycle capture:
  - dden=0000: idle, nothing captured.
  - dden one-hot with index i: digit[i] <= decoded value (0 if invalid), mask[i] <= 1. An invalid glyph sets the frame-error flag.
  - dden multi-hot: sets the frame-error flag, nothing captured.
  - Duplicate slot (mask[i] already 1 before the frame completes): frame restarts with mask = only bit i and the error flag cleared, then this sample is evaluated as the first of a new frame.
- Frame complete (the capture edge at which mask becomes 1111 = edge E):
  - Error flag set: err pulses at edge E+1; frame dropped; match count unchanged; no conversion.
  - Otherwise: the four digits are snapshotted into conversion registers, and mask and flag clear at E so the next frame captures in parallel.
  - A completion while CONV is busy cannot occur at one sample per clock; if forced, the new frame is dropped silently.
- FSM IDLE -> CONV (4 cycles) -> CMP -> IDLE:
  - CONV: acc starts at 0; for k=3 down to 0, acc <= (acc<<3)+(acc<<1)+digit[k]. 14-bit unsigned arithmetic; max 9999, no overflow.
  - CMP:
    - If acc equals the previous converted value, match count increments, saturating at STABLE; otherwise match count = 1 and previous = acc.
    - If match count (after update) reaches STABLE and (have-data=0 or acc != data): data <= acc, valid pulse, have-data <= 1.
    - If acc equals data, data is unchanged and there is no pulse.
- Latency: data/valid update at edge E+5 relative to the completing capture edge. With STABLE=2 and a constant source, the first valid occurs 5 cycles after the 2nd complete frame.
- err and valid are never asserted together for the same frame; each is a single-cycle pulse.

Test Plan:
- Drive the transmitter encoding of 1234 on dden 0001,0010,0100,1000 repeating -> the first frame gives no valid; valid pulses once with data=1234 at E+5 of the second frame; no further pulses while the value is held.
- Change the source from 1234 to 0007 mid-stream -> data stays 1234 through a partial or mixed frame; valid pulses with data=7 after 2 clean 0007 frames.
- Inject glyph 0000000 on digit 2 for one frame of 5555 -> err pulses once at E+1; no valid; the next two clean 5555 frames yield valid with data=5555.
- Drive dden=0011 for one cycle -> err pulses at that frame's completion. Drive dden=0000 for 3 cycles between digits -> ignored; the frame still completes and decodes correctly.
- Repeat dden=0001 twice before 0010 (duplicate slot) -> the frame restarts, no err, correct value later. Send 9999 -> data=9999 (14'h270F). Send 0000 after reset -> valid with data=0 (have-data path).
- Assert rstn low during CONV of a 4321 frame -> data=0 and valid=0 immediately (asynchronous); after release, 2 clean frames are required before valid with data=4321.

Source files
------------

// File: rtl/tdmseg4_rx.sv
// tdmseg4_rx - receiver for a 4-digit time-multiplexed 7-segment display bus.
//
// Samples the glyph and one-hot digit enable on every clock and decodes each
// glyph back to BCD. It assembles 4-digit frames and converts each clean frame
// to binary. A value is published only after STABLE identical frames in a row.
//
// Ports:
//   clk      system clock (the clock the display bus is launched on)
//   rstn     asynchronous active-low reset
//   segment  glyph, bit6..bit0 = G,F,E,D,C,B,A, 1 = lit
//   dden     one-hot digit enable, dden[0] = least significant digit
//   data     last stable decoded value, binary 0-9999
//   valid    one-cycle pulse when data is loaded with a new value
//   err      one-cycle pulse when a frame is discarded
module tdmseg4_rx #(
  parameter int STABLE = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [6:0]  segment,
  input  logic [3:0]  dden,
  output logic [13:0] data,
  output logic        valid,
  output logic        err
);

  localparam logic [3:0] STB = 4'(STABLE);

  typedef enum logic {IDLE, CONV} state_t;

  // Strict glyph decode: returns {ok, bcd}; anything off-table is invalid.
  function automatic logic [4:0] dec7(input logic [6:0] g);
    case (g)
      7'b0111111: dec7 = 5'h10;
      7'b0000110: dec7 = 5'h11;
      7'b1011011: dec7 = 5'h12;
      7'b1001111: dec7 = 5'h13;
      7'b1100110: dec7 = 5'h14;
      7'b1101101: dec7 = 5'h15;
      7'b1111100: dec7 = 5'h16;
      7'b0000111: dec7 = 5'h17;
      7'b1111111: dec7 = 5'h18;
      7'b1100111: dec7 = 5'h19;
      default:    dec7 = 5'h00;
    endcase
  endfunction

  logic [3:0]  dig    [4];
  logic [3:0]  dig_n  [4];
  logic [3:0]  dig_p0 [4];
  logic [3:0]  mask, mask_n;
  logic        ferr, ferr_n;
  logic [4:0]  dec;
  logic        onehot;
  logic [1:0]  idx;
  logic        done, accept;
  state_t      state;
  logic [1:0]  cnt;
  logic [13:0] acc_p1;
  logic [13:0] prev;
  logic        vld_p2;
  logic        errv_p1;
  logic [3:0]  mcnt, mcnt_n;
  logic        have;
  logic        load;

  assign dec    = dec7(segment);
  assign onehot = (dden != 4'd0) && ((dden & (dden - 4'd1)) == 4'd0);

  always_comb begin
    case (dden)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
  end

  // Next frame state for this sample. A slot seen twice restarts the frame
  // with this sample as its first digit, so a stale error does not survive.
  always_comb begin
    dig_n  = dig;
    mask_n = mask;
    ferr_n = ferr;
    if (onehot) begin
      dig_n[idx] = dec[4] ? dec[3:0] : 4'd0;
      if ((mask & dden) != 4'd0) begin
        mask_n = dden;
        ferr_n = ~dec[4];
      end else begin
        mask_n = mask | dden;
        ferr_n = ferr | ~dec[4];
      end
    end else if (dden != 4'd0) begin
      ferr_n = 1'b1;
    end
  end

  assign done = (mask_n == 4'hF);
  // Back-to-back frames complete exactly on the last conversion step, so the
  // engine accepts a new snapshot then as well as when idle.
  assign accept = done && !ferr_n &&
                  ((state == IDLE) || (cnt == 2'd0));

  always_comb begin
    if (acc_p1 == prev)
      mcnt_n = (mcnt >= STB) ? STB : mcnt + 4'd1;
    else
      mcnt_n = 4'd1;
  end

  assign load = vld_p2 && (mcnt_n == STB) && (!have || (acc_p1 != data));

  // Control and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mask    <= 4'd0;
      ferr    <= 1'b0;
      errv_p1 <= 1'b0;
      err     <= 1'b0;
      state   <= IDLE;
      cnt     <= 2'd0;
      vld_p2  <= 1'b0;
      mcnt    <= 4'd0;
      have    <= 1'b0;
      data    <= 14'd0;
      valid   <= 1'b0;
    end else begin
      // Stage: frame capture.
      if (done) begin
        mask <= 4'd0;
        ferr <= 1'b0;
      end else begin
        mask <= mask_n;
        ferr <= ferr_n;
      end
      errv_p1 <= done && ferr_n;
      err     <= errv_p1;

      // Stage: BCD-to-binary conversion, one digit per cycle.
      vld_p2 <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= CONV;
            cnt   <= 2'd3;
          end
        end
        CONV: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd0) begin
            vld_p2 <= 1'b1;
            if (accept)
              cnt <= 2'd3;
            else
              state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Stage: stability compare and publish.
      valid <= 1'b0;
      if (vld_p2) begin
        mcnt <= mcnt_n;
        if (load) begin
          data  <= acc_p1;
          valid <= 1'b1;
          have  <= 1'b1;
        end
      end
    end
  end

  // Datapath registers; their contents are qualified by the control above.
  always_ff @(posedge clk) begin
    dig <= dig_n;
    if (accept)
      dig_p0 <= dig_n;
    // The first step starts the accumulator from zero.
    if (state == CONV)
      acc_p1 <= ((cnt == 2'd3) ? 14'd0 : (acc_p1 << 3) + (acc_p1 << 1)) +
                {10'd0, dig_p0[cnt]};
    if (vld_p2 && (acc_p1 != prev))
      prev <= acc_p1;
  end

endmodule
